// File: rtl/oled_init_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_init_seq: walks the OLED init command ROM and streams each byte to  |
// | the byte transmitter over valid/ready after a power-up delay.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module oled_init_seq #(
    parameter int NUM_BYTES    = 31,
    parameter int PWRUP_CYCLES = 1000000,
    parameter bit REINIT_PWRUP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic       init_done
);

    localparam int                CNT_W      = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [5:0]        c_idx_last = 6'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_PWR  = 3'd0,
        ST_ADDR = 3'd1,
        ST_LAT  = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         idx_q, idx_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               init_done_q, init_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWR;
            cnt_q       <= '0;
            idx_q       <= 6'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;

        case (state_q)
            ST_PWR: begin
                if (cnt_q == c_cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // ROM registers the address at the end of this cycle.
            ST_ADDR: state_d = ST_LAT;
            ST_LAT: begin
                tx_data_d  = rom_data;
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == c_idx_last) begin
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    idx_d       = 6'd0;
                    busy_d      = 1'b1;
                    init_done_d = 1'b0;
                    state_d     = REINIT_PWRUP ? ST_PWR : ST_ADDR;
                end
            end
            default: state_d = ST_PWR;
        endcase
    end

    // The byte index register doubles as the registered ROM address.
    assign rom_addr  = idx_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: doc/oled_init_seq.md
Name: oled_init_seq

Overview:
- Sequencer that walks the OLED initialisation command ROM byte by byte and hands each byte to the downstream I2C/SPI byte transmitter over a valid/ready handshake.
- Inserts a power-up delay after reset, then reports completion to the display-refresh logic.
- Supports a re-initialisation request after completion.
- Sits between the init command ROM (6-bit address, one-cycle registered-address latency) and the OLED byte transmitter.

Parameters:
- NUM_BYTES, 31, number of ROM bytes to send (1..64); addresses 0..NUM_BYTES-1.
- PWRUP_CYCLES, 1000000, clk cycles to wait after reset before the first ROM fetch (>=1).
- REINIT_PWRUP, 0, 1 = re-init request also runs the power-up delay; 0 = re-init skips it.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  re-init request pulse; honoured only in DONE
- rom_addr  out  6  address to init ROM, registered
- rom_data  in  8  ROM output, valid one cycle after rom_addr is sampled
- tx_valid  out  1  command byte available on tx_data
- tx_data  out  8  command byte to transmitter, registered
- tx_ready  in  1  transmitter accepts byte this cycle (transfer = tx_valid & tx_ready)
- busy  out  1  sequence in progress (any state except DONE)
- init_done  out  1  all NUM_BYTES transferred; held until re-init or reset

Behaviour:
- Reset (async, rst_n=0):
  - state=PWR, delay counter=0, byte index=0, rom_addr=0.
  - tx_valid=0, tx_data=8'h00, busy=1, init_done=0.
  - All outputs are registers; no combinational path from inputs to outputs.
- States: PWR, ADDR, LAT, SEND, DONE.
- PWR:
  - Counter increments each cycle.
  - When counter==PWRUP_CYCLES-1: clear counter, go to ADDR.
- ADDR:
  - rom_addr holds the index; the ROM samples it at the end of this cycle.
  - Next state is LAT unconditionally.
- LAT:
  - rom_data is valid.
  - At end of cycle: tx_data<=rom_data, tx_valid<=1, go to SEND.
- SEND:
  - Hold tx_valid=1 and tx_data stable until tx_ready=1.
  - On transfer, tx_valid<=0.
  - If index==NUM_BYTES-1: go to DONE, busy<=0, init_done<=1.
  - Otherwise: index<=index+1, rom_addr<=index+1, go to ADDR.
- DONE:
  - rom_addr holds the last index; tx_valid=0.
  - On start=1: index<=0, rom_addr<=0, busy<=1, init_done<=0.
  - Next state is PWR if REINIT_PWRUP=1, else ADDR.
- Throughput: minimum 3 cycles per byte (ADDR, LAT, SEND with tx_ready=1). tx_valid is never high in back-to-back cycles across bytes.
- Bytes are sent strictly in address order 0..NUM_BYTES-1, each exactly once per sequence. No byte may be skipped or duplicated under any tx_ready pattern.
- start is ignored in PWR/ADDR/LAT/SEND; no queuing.
- tx_ready is ignored when tx_valid=0.
- Reset mid-sequence aborts immediately:
  - tx_valid drops asynchronously.
  - After reset release, the sequence restarts from PWR and index 0.
- Index counter is 6 bits; no wrap past NUM_BYTES-1, since DONE is entered instead.
- busy and init_done are never both 1, and are never both 0 after reset.

Test Plan:
- Nominal: PWRUP_CYCLES=4, NUM_BYTES=31, tx_ready tied 1 -> exactly 31 transfers, values 0xAE, 0xD5, 0xF0 … 0x22, 0x00, 0x07 in order. First tx_valid is high in cycle 7 after reset release (4 PWR + ADDR + LAT). init_done rises 93 cycles after leaving PWR; busy falls in the same cycle.
- Backpressure: tx_ready low for 5 cycles on byte 3 (0xA8) and randomly elsewhere -> tx_valid and tx_data=0xA8 held stable throughout. Sequence identical, no loss or duplication, 31 transfers total.
- Ignored start: pulse start during PWR and during SEND of byte 10 -> no restart, sequence completes normally with 31 bytes.
- Re-init: after DONE, 1-cycle start pulse with REINIT_PWRUP=0 -> init_done=0 and busy=1 next cycle. rom_addr=0, tx_data=0xAE valid 2 cycles later, full 31-byte resend.
- Reset mid-operation: assert rst_n=0 during SEND of byte 15 -> tx_valid=0, busy=1, init_done=0, rom_addr=0 immediately. After release, 4-cycle PWR delay then restart from 0xAE.
- Short table: NUM_BYTES=1 -> single transfer of 0xAE, then DONE. No rom_addr value above 0 is ever driven.
